// File: rtl/motor_ramp_sequencer.sv
// Motor duty ramp sequencer.
// Moves the applied duty toward a requested target in bounded steps per tick.
// A direction reversal is sequenced as brake to zero, dwell at zero, then ramp.
// An obstruction while moving forward forces an immediate emergency stop.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | duty at target, waiting for a request
//   RAMP  | stepping duty toward target_dc on each tick
//   BRAKE | stepping duty down to zero ahead of a direction flip
//   DWELL | holding zero duty for DWELL_TICKS ticks, then flipping direction
//   ESTOP | duty forced to zero, waiting for the obstruction to clear
module motor_ramp_sequencer #(
  parameter int STEP        = 16,
  parameter int DWELL_TICKS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_dc,
  input  logic       req_dir,
  input  logic       can_move_fwd,
  output logic [7:0] motor_dc,
  output logic       direction,
  output logic       busy,
  output logic [2:0] seq_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RAMP  = 3'd1,
    BRAKE = 3'd2,
    DWELL = 3'd3,
    ESTOP = 3'd4
  } state_t;

  localparam logic [7:0] STEP8  = 8'(STEP);
  localparam logic [7:0] DWELL8 = 8'(DWELL_TICKS);

  state_t     state_q, state_d;
  logic [7:0] dc_d;
  logic       dir_d;
  logic [7:0] tdc_q, tdc_d;
  logic       tdir_q, tdir_d;
  logic [7:0] cnt_q, cnt_d;

  logic       estop_cond;
  logic       accept;
  logic       ramp_up;
  logic [7:0] ramp_diff;
  logic [7:0] ramp_step;
  logic [7:0] ramp_dc;
  logic [7:0] brake_dc;

  // Obstruction only matters while actually moving forward.
  assign estop_cond = ~can_move_fwd & direction & (motor_dc != 8'd0);
  assign req_ready  = (state_q != ESTOP) & ~estop_cond;
  assign accept     = req_valid & req_ready;

  assign busy      = (state_q != IDLE);
  assign seq_state = state_q;

  // Step toward target by at most STEP; the step never exceeds the gap,
  // so neither direction can wrap.
  assign ramp_up   = (tdc_q > motor_dc);
  assign ramp_diff = ramp_up ? (tdc_q - motor_dc) : (motor_dc - tdc_q);
  assign ramp_step = (ramp_diff > STEP8) ? STEP8 : ramp_diff;
  assign ramp_dc   = ramp_up ? (motor_dc + ramp_step) : (motor_dc - ramp_step);
  assign brake_dc  = (motor_dc > STEP8) ? (motor_dc - STEP8) : 8'd0;

  // State and datapath registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      motor_dc  <= 8'd0;
      direction <= 1'b1;
      tdc_q     <= 8'd0;
      tdir_q    <= 1'b1;
      cnt_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      motor_dc  <= dc_d;
      direction <= dir_d;
      tdc_q     <= tdc_d;
      tdir_q    <= tdir_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next state and datapath: estop first, then ESTOP hold, then accept, then tick.
  always_comb begin
    state_d = state_q;
    dc_d    = motor_dc;
    dir_d   = direction;
    tdc_d   = tdc_q;
    tdir_d  = tdir_q;
    cnt_d   = cnt_q;

    if (estop_cond) begin
      dc_d    = 8'd0;
      tdc_d   = 8'd0;
      state_d = ESTOP;
    end else if (state_q == ESTOP) begin
      if (can_move_fwd) state_d = IDLE;
    end else if (accept) begin
      tdc_d  = req_dc;
      tdir_d = req_dir;
      if (req_dir == direction) begin
        state_d = (req_dc == motor_dc) ? IDLE : RAMP;
      end else if (motor_dc != 8'd0) begin
        state_d = BRAKE;
      end else begin
        state_d = DWELL;
        cnt_d   = DWELL8;
      end
    end else begin
      case (state_q)
        RAMP: begin
          // Also settles a RAMP entered with duty already at target.
          if (tick) dc_d = ramp_dc;
          if (dc_d == tdc_q) state_d = IDLE;
        end
        BRAKE: begin
          if (tick) begin
            dc_d = brake_dc;
            if (brake_dc == 8'd0) begin
              state_d = DWELL;
              cnt_d   = DWELL8;
            end
          end
        end
        DWELL: begin
          if (tick) begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
              dir_d   = tdir_q;
              state_d = RAMP;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/motor_ramp_sequencer.md
MOTOR_RAMP_SEQUENCER -- requirements
Module: motor_ramp_sequencer

Interface
REQ-001 SHALL have parameter STEP, default 16, max duty change per tick (1..255).
REQ-002 SHALL have parameter DWELL_TICKS, default 8, ticks held at zero duty before a direction flip (1..255).
REQ-003 SHALL have port clk  input  1  system clock; the only clock.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port tick  input  1  single-cycle ramp-step enable.
REQ-006 SHALL have port req_valid  input  1  new target offered.
REQ-007 SHALL have port req_ready  output  1  target can be accepted this cycle.
REQ-008 SHALL have port req_dc  input  8  requested motor duty.
REQ-009 SHALL have port req_dir  input  1  requested direction, 1=forward.
REQ-010 SHALL have port can_move_fwd  input  1  0 = obstruction ahead.
REQ-011 SHALL have port motor_dc  output  8  registered applied duty.
REQ-012 SHALL have port direction  output  1  registered applied direction.
REQ-013 SHALL have port busy  output  1  high when state != IDLE.
REQ-014 SHALL have port seq_state  output  3  IDLE=0, RAMP=1, BRAKE=2, DWELL=3, ESTOP=4.

Function
REQ-015 SHALL define estop_cond = ~can_move_fwd & direction & (motor_dc != 0).
REQ-016 SHALL drive req_ready combinationally = (seq_state != ESTOP) & ~estop_cond; accept = req_valid & req_ready.
REQ-017 SHALL, on accept, load target_dc <= req_dc and target_dir <= req_dir; a later accept overwrites the earlier one.
REQ-018 SHALL, on accept with req_dir == direction, enter RAMP, or IDLE if req_dc == motor_dc; valid from IDLE, RAMP, BRAKE and DWELL.
REQ-019 SHALL, on accept with req_dir != direction and motor_dc != 0, enter BRAKE.
REQ-020 SHALL, on accept with req_dir != direction and motor_dc == 0, enter DWELL with the dwell counter loaded to DWELL_TICKS.
REQ-021 SHALL, in RAMP on tick, move motor_dc toward target_dc by min(STEP, |target_dc - motor_dc|), with no overflow or underflow; enter IDLE in the cycle motor_dc equals target_dc.
REQ-022 SHALL, in BRAKE on tick, set motor_dc <= (motor_dc > STEP) ? motor_dc - STEP : 0; on reaching 0, enter DWELL with the counter loaded to DWELL_TICKS.
REQ-023 SHALL, in DWELL on tick, decrement the counter; on the tick that makes it 0, set direction <= target_dir and enter RAMP.
REQ-024 SHALL leave motor_dc, direction and the counter unchanged in cycles without tick, except as REQ-025 requires.
REQ-025 SHALL, when estop_cond is high in any state, set motor_dc <= 0 and target_dc <= 0 next cycle, enter ESTOP and accept no request that cycle; estop has priority over tick and accept.
REQ-026 SHALL hold ESTOP, with req_ready = 0, until can_move_fwd == 1, then enter IDLE the next cycle with direction unchanged.
REQ-027 SHALL never apply estop when direction == 0; reverse motion ignores can_move_fwd.
REQ-028 SHALL change direction only while motor_dc == 0.

Reset
REQ-029 SHALL, while rst is high at a clk edge, set motor_dc=0, direction=1, target_dc=0, target_dir=1, counter=0 and seq_state=IDLE, so busy=0; this overrides every other event, including mid-RAMP, mid-DWELL and ESTOP.
REQ-030 SHALL hold req_ready=1 after reset while can_move_fwd is any value, because motor_dc=0 makes estop_cond 0.

Verification (STEP=16, DWELL_TICKS=8)
REQ-031 SHALL cover: reset, then accept dc=70 dir=1, 5 ticks -> motor_dc 16,32,48,64,70; then IDLE, busy=0.
REQ-032 SHALL cover: at dc=48 forward, accept dc=40 dir=0 -> BRAKE 32,16,0; DWELL for 8 ticks with direction=1; then direction=0; RAMP 16,32,40; IDLE.
REQ-033 SHALL cover: in DWELL after tick 3, accept dc=32 dir=1 -> RAMP, direction stays 1, motor_dc 16,32.
REQ-034 SHALL cover: at dc=48 forward, can_move_fwd=0 with req_valid=1 in the same cycle -> request not accepted; next cycle motor_dc=0, ESTOP, req_ready=0; can_move_fwd=1 -> IDLE next cycle.
REQ-035 SHALL cover: reverse at dc=32 with can_move_fwd=0 -> no ESTOP; ticks continue ramping normally.
REQ-036 SHALL cover: rst pulse mid-RAMP at dc=48 -> next cycle motor_dc=0, direction=1, IDLE, req_ready=1.
